seq_divider: RTL and testbench

//  Multi-cycle 32-bit integer divider for the RV32M divide group (DIV, DIVU, REM, REMU).
//  It is the inverse-operation companion of the combinational MULT unit in the DSP/ALU path.

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/seq_divider_if.sv | 14 +
 rtl/seq_divider_step.sv | 19 +
 rtl/seq_divider.sv | 79 +++++++
 tb/tb_seq_divider.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// div_pkg: shared width, op and state encodings for the sequential divider
package div_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = $clog2(XLEN);
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done request and result bundle of the divider
interface seq_divider_if;
  import div_pkg::*;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master (output start, op, a, b, input ready, busy, done, result);
  modport slave (input start, op, a, b, output ready, busy, done, result);
endinterface

// File: rtl/seq_divider_step.sv
// div_step: one restoring iteration, shift in next dividend bit and trial-subtract
module div_step
  import div_pkg::*;
(
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);
  logic [XLEN+1:0] sh;
  logic [XLEN+1:0] trial;
  always_comb begin
    sh = {rem, quo[XLEN-1]};
    trial = sh - {2'b00, divisor};
    rem_nxt = trial[XLEN+1] ? sh[XLEN:0] : trial[XLEN:0];
    quo_nxt = {quo[XLEN-2:0], ~trial[XLEN+1]};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one bit per clock
module seq_divider
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave dif
);
  div_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]   rem, rem_nxt;
  logic [XLEN-1:0] quo, quo_nxt, dvs, result;
  logic            is_rem, qsign, rsign, done_r;
  logic            sgn, div0, ovf;
  div_step u_step (
    .rem(rem),
    .quo(quo),
    .divisor(dvs),
    .rem_nxt(rem_nxt),
    .quo_nxt(quo_nxt)
  );
  always_comb begin
    sgn = ~dif.op[0];
    div0 = dif.b == '0;
    ovf = sgn && dif.a == {1'b1, {(XLEN-1){1'b0}}} && &dif.b;
    state_nxt = state;
    case (state)
      IDLE: state_nxt = dif.start ? ((div0 || ovf) ? DONE : CALC) : IDLE;
      CALC: state_nxt = (cnt == '0) ? FIX : CALC;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // Operands are reduced to magnitudes at start; signs are reapplied in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      is_rem <= 1'b0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      result <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= state == DONE;
      case (state)
        IDLE: if (dif.start) begin
          is_rem <= dif.op[1];
          qsign <= sgn & (dif.a[XLEN-1] ^ dif.b[XLEN-1]);
          rsign <= sgn & dif.a[XLEN-1];
          quo <= cneg(dif.a, sgn & dif.a[XLEN-1]);
          dvs <= cneg(dif.b, sgn & dif.b[XLEN-1]);
          rem <= '0;
          cnt <= CNT_W'(XLEN - 1);
          if (div0) result <= dif.op[1] ? dif.a : '1;
          else if (ovf) result <= dif.op[1] ? '0 : dif.a;
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: result <= is_rem ? cneg(rem[XLEN-1:0], rsign) : cneg(quo, qsign);
        default: ;
      endcase
    end
  end
  assign dif.ready = state == IDLE;
  assign dif.busy = state == CALC;
  assign dif.done = done_r;
  assign dif.result = result;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench with directed divide vectors, handshake and abort checks
module tb_seq_divider;
  import div_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seq_divider_if dif ();
  seq_divider dut (.clk(clk), .rst(rst), .dif(dif.slave));
  typedef struct {
    string       name;
    logic [31:0] res;
    int          t0;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dones = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && dif.done) begin
      exp_t e;
      dones++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got result %h expected no done", dif.result);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, dif.result, e.res);
        chk({e.name, "_latency"}, 32'(cyc - e.t0 - 1), 32'(e.lat));
      end
    end
  end
  task automatic issue(input string n, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat);
    @(negedge clk);
    for (int i = 0; i < 50 && !dif.ready; i++) @(negedge clk);
    dif.start = 1'b1;
    dif.op = op;
    dif.a = a;
    dif.b = b;
    sb.push_back('{n, res, cyc, lat});
    @(negedge clk);
    dif.start = 1'b0;
  endtask
  task automatic wait_empty();
    int i;
    for (i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    int d0;
    dif.start = 1'b0;
    dif.op = 2'b00;
    dif.a = '0;
    dif.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(dif.ready), 32'd1);
    chk("reset_busy", 32'(dif.busy), 32'd0);
    chk("reset_done", 32'(dif.done), 32'd0);
    chk("reset_result", dif.result, 32'h0);
    rst = 1'b0;
    issue("div_100_7", DIV_OP_DIV, 32'd100, 32'd7, 32'h0000000E, 34);
    wait_empty();
    issue("rem_100_7", DIV_OP_REM, 32'd100, 32'd7, 32'h00000002, 34);
    wait_empty();
    issue("div_m7_2", DIV_OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 34);
    wait_empty();
    issue("rem_m7_2", DIV_OP_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 34);
    wait_empty();
    issue("rem_7_m2", DIV_OP_REM, 32'h7, 32'hFFFFFFFE, 32'h00000001, 34);
    wait_empty();
    issue("divu_max_2", DIV_OP_DIVU, 32'hFFFFFFFF, 32'h2, 32'h7FFFFFFF, 34);
    wait_empty();
    issue("remu_max_2", DIV_OP_REMU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 34);
    wait_empty();
    issue("divu_min_max", DIV_OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0, 34);
    wait_empty();
    issue("div_5_0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    wait_empty();
    issue("remu_5_0", DIV_OP_REMU, 32'd5, 32'd0, 32'h00000005, 1);
    wait_empty();
    issue("div_ovf", DIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    wait_empty();
    issue("rem_ovf", DIV_OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    wait_empty();
    issue("div_min_2", DIV_OP_DIV, 32'h80000000, 32'h2, 32'hC0000000, 34);
    wait_empty();
    d0 = dones;
    issue("div_ignored_start", DIV_OP_DIV, 32'd100, 32'd7, 32'h0000000E, 34);
    repeat (3) @(negedge clk);
    chk("busy_in_calc", 32'(dif.busy), 32'd1);
    dif.start = 1'b1;
    dif.op = DIV_OP_DIVU;
    dif.a = 32'd1;
    dif.b = 32'd1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_empty();
    repeat (40) @(negedge clk);
    chk("single_done", 32'(dones - d0), 32'd1);
    @(negedge clk);
    dif.start = 1'b1;
    dif.op = DIV_OP_DIVU;
    dif.a = 32'd1000;
    dif.b = 32'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(dif.ready), 32'd1);
    chk("abort_busy", 32'(dif.busy), 32'd0);
    chk("abort_done", 32'(dif.done), 32'd0);
    chk("abort_result", dif.result, 32'h0);
    d0 = dones;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(dones - d0), 32'd0);
    issue("remu_after_abort", DIV_OP_REMU, 32'd1000, 32'd3, 32'h00000001, 34);
    wait_empty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
